// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - hazard detection, stall/bubble control and mul/div sequencing
//
// Purpose:
//   Detects the hazards that forwarding cannot resolve in the 5-stage pipeline
//   (load-use, ID-stage branch operand not ready, HI/LO busy) and drives PC /
//   IF-ID hold plus ID-EX bubble insertion. Also sequences the multi-cycle
//   mul/div unit: issues a one-cycle start pulse and tracks busy.
//
// Configuration macro:
//   HAZARD_PERF_CNT_EN - when defined, stall_cycles_o is a saturating count of
//                        cycles with pc_stall_o=1; otherwise it is tied to 0.
//
// Ports:
//   clk_i               pipeline clock, rising edge
//   rst_i               synchronous active-high reset
//   if_id_rs_i/rt_i     source registers of the instruction in ID
//   if_id_use_rs_i/rt_i ID instruction reads rs / rt
//   if_id_branch_i      ID instruction is a branch/jr resolved in ID
//   if_id_hilo_use_i    ID instruction touches HI/LO
//   id_ex_memread_i     EX instruction is a load
//   id_ex_regwrite_i    EX instruction writes a GPR
//   id_ex_regdst_i      EX destination register
//   id_ex_md_op_i       EX mul/div op (00 none, 01 mul, 10 div, 11 none)
//   ex_mem_memread_i    MEM instruction is a load
//   ex_mem_regdst_i     MEM destination register
//   pc_stall_o          hold PC
//   if_id_stall_o       hold IF/ID register
//   id_ex_flush_o       load bubble into ID/EX
//   md_start_o          one-cycle start pulse to mul/div unit
//   md_busy_o           mul/div computing, HI/LO not valid
//   stall_cycles_o      stall performance counter

module hazard_stall_controller #(
    parameter int MUL_LATENCY = 4,
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       if_id_rs_i,
    input  logic [4:0]       if_id_rt_i,
    input  logic             if_id_use_rs_i,
    input  logic             if_id_use_rt_i,
    input  logic             if_id_branch_i,
    input  logic             if_id_hilo_use_i,
    input  logic             id_ex_memread_i,
    input  logic             id_ex_regwrite_i,
    input  logic [4:0]       id_ex_regdst_i,
    input  logic [1:0]       id_ex_md_op_i,
    input  logic             ex_mem_memread_i,
    input  logic [4:0]       ex_mem_regdst_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             id_ex_flush_o,
    output logic             md_start_o,
    output logic             md_busy_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    // Down-counter only ever holds LATENCY-1, so clog2(max latency) bits suffice.
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LATENCY - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          md_start;
    logic          md_busy;
    logic          hz_load_use;
    logic          hz_branch;
    logic          hz_hilo;
    logic          stall;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst,
                                       input logic [4:0] src,
                                       input logic       use_src);
        return use_src && (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic id_match(input logic [4:0] dst);
        return reg_match(dst, if_id_rs_i, if_id_use_rs_i) ||
               reg_match(dst, if_id_rt_i, if_id_use_rt_i);
    endfunction

    // Mul/div sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (id_ex_md_op_i == 2'b01 || id_ex_md_op_i == 2'b10) begin
                    md_start = 1'b1;
                    cnt_d    = (id_ex_md_op_i == 2'b01) ? MUL_LOAD : DIV_LOAD;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // A new md op seen here is ignored: no restart while computing.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy = (state_q == BUSY);

    // Hazard detection
    // EX-stage ALU results can be forwarded to EX but not to the ID-stage
    // comparator; a load in MEM is not ready for ID either.
    assign hz_load_use = id_ex_memread_i && id_match(id_ex_regdst_i);
    assign hz_branch   = if_id_branch_i &&
                         ((id_ex_regwrite_i && id_match(id_ex_regdst_i)) ||
                          (ex_mem_memread_i && id_match(ex_mem_regdst_i)));
    // md_start counts as busy so a HI/LO user right behind the op also waits.
    assign hz_hilo     = if_id_hilo_use_i && (md_busy || md_start);

    assign stall = !rst_i && (hz_load_use || hz_branch || hz_hilo);

    assign pc_stall_o    = stall;
    assign if_id_stall_o = stall;
    assign id_ex_flush_o = stall;
    assign md_start_o    = md_start && !rst_i;
    assign md_busy_o     = md_busy && !rst_i;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles_o = rst_i ? '0 : stall_cnt_q;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed self-checking bench for hazard_stall_controller

module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  if_id_rs, if_id_rt;
    logic        if_id_use_rs, if_id_use_rt, if_id_branch, if_id_hilo_use;
    logic        id_ex_memread, id_ex_regwrite;
    logic [4:0]  id_ex_regdst;
    logic [1:0]  id_ex_md_op;
    logic        ex_mem_memread;
    logic [4:0]  ex_mem_regdst;

    logic        pc_stall, if_id_stall, id_ex_flush, md_start, md_busy;
    logic [31:0] stall_cycles;
    logic        s_pc_stall, s_if_id_stall, s_id_ex_flush, s_md_start, s_md_busy;
    logic [1:0]  s_stall_cycles;

    int checks = 0;
    int errors = 0;
    int n_stall;
    int n_busy;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    hazard_stall_controller #(.MUL_LATENCY(4), .DIV_LATENCY(32), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_id_rs_i(if_id_rs), .if_id_rt_i(if_id_rt),
        .if_id_use_rs_i(if_id_use_rs), .if_id_use_rt_i(if_id_use_rt),
        .if_id_branch_i(if_id_branch), .if_id_hilo_use_i(if_id_hilo_use),
        .id_ex_memread_i(id_ex_memread), .id_ex_regwrite_i(id_ex_regwrite),
        .id_ex_regdst_i(id_ex_regdst), .id_ex_md_op_i(id_ex_md_op),
        .ex_mem_memread_i(ex_mem_memread), .ex_mem_regdst_i(ex_mem_regdst),
        .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .id_ex_flush_o(id_ex_flush),
        .md_start_o(md_start), .md_busy_o(md_busy), .stall_cycles_o(stall_cycles)
    );

    hazard_stall_controller #(.MUL_LATENCY(4), .DIV_LATENCY(32), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .if_id_rs_i(if_id_rs), .if_id_rt_i(if_id_rt),
        .if_id_use_rs_i(if_id_use_rs), .if_id_use_rt_i(if_id_use_rt),
        .if_id_branch_i(if_id_branch), .if_id_hilo_use_i(if_id_hilo_use),
        .id_ex_memread_i(id_ex_memread), .id_ex_regwrite_i(id_ex_regwrite),
        .id_ex_regdst_i(id_ex_regdst), .id_ex_md_op_i(id_ex_md_op),
        .ex_mem_memread_i(ex_mem_memread), .ex_mem_regdst_i(ex_mem_regdst),
        .pc_stall_o(s_pc_stall), .if_id_stall_o(s_if_id_stall), .id_ex_flush_o(s_id_ex_flush),
        .md_start_o(s_md_start), .md_busy_o(s_md_busy), .stall_cycles_o(s_stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        if_id_rs = 5'd0; if_id_rt = 5'd0;
        if_id_use_rs = 1'b0; if_id_use_rt = 1'b0;
        if_id_branch = 1'b0; if_id_hilo_use = 1'b0;
        id_ex_memread = 1'b0; id_ex_regwrite = 1'b0;
        id_ex_regdst = 5'd0; id_ex_md_op = 2'b00;
        ex_mem_memread = 1'b0; ex_mem_regdst = 5'd0;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check({tag, ".pc_stall"}, {31'd0, pc_stall}, {31'd0, exp});
        check({tag, ".if_id_stall"}, {31'd0, if_id_stall}, {31'd0, exp});
        check({tag, ".id_ex_flush"}, {31'd0, id_ex_flush}, {31'd0, exp});
    endtask

    task automatic check_counters(input string tag, input int n);
        int sat;
        sat = (n > 3) ? 3 : n;
        check({tag, ".stall_cycles"}, stall_cycles, PERF ? n : 0);
        check({tag, ".stall_cycles_sat"}, {30'd0, s_stall_cycles}, PERF ? sat : 0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        // Hazard-causing inputs during reset must not produce any output.
        id_ex_memread = 1'b1; id_ex_regdst = 5'd9; if_id_rs = 5'd9; if_id_use_rs = 1'b1;
        id_ex_md_op = 2'b10; if_id_hilo_use = 1'b1;
        tick(); tick();
        settle();
        check_stall("rst", 1'b0);
        check("rst.md_start", {31'd0, md_start}, 32'd0);
        check("rst.md_busy", {31'd0, md_busy}, 32'd0);
        check_counters("rst", 0);

        rst = 1'b0;
        clear_inputs();
        settle();
        check_stall("idle", 1'b0);
        check("idle.md_busy", {31'd0, md_busy}, 32'd0);

        // Load-use via rs, then bubble in EX
        id_ex_memread = 1'b1; id_ex_regdst = 5'd9; if_id_rs = 5'd9; if_id_use_rs = 1'b1;
        settle(); check_stall("lu_rs", 1'b1);
        tick(); id_ex_memread = 1'b0; id_ex_regdst = 5'd0;
        settle(); check_stall("lu_rs_after", 1'b0);
        tick(); clear_inputs();
        // Load-use via rt
        id_ex_memread = 1'b1; id_ex_regdst = 5'd12; if_id_rt = 5'd12; if_id_use_rt = 1'b1;
        settle(); check_stall("lu_rt", 1'b1);
        tick(); clear_inputs();
        // Load-use on r31
        id_ex_memread = 1'b1; id_ex_regdst = 5'd31; if_id_rs = 5'd31; if_id_use_rs = 1'b1;
        settle(); check_stall("lu_r31", 1'b1);
        tick(); clear_inputs();
        settle(); check_counters("after_lu", 3);

        // Register 0 never matches; unused source never matches
        id_ex_memread = 1'b1; id_ex_regdst = 5'd0; if_id_rs = 5'd0; if_id_use_rs = 1'b1;
        settle(); check_stall("lu_r0", 1'b0);
        if_id_use_rs = 1'b0; id_ex_regdst = 5'd9; if_id_rs = 5'd9;
        settle(); check_stall("lu_nouse", 1'b0);
        // Non-branch with MEM load match is covered by forwarding
        clear_inputs(); ex_mem_memread = 1'b1; ex_mem_regdst = 5'd8;
        if_id_rs = 5'd8; if_id_use_rs = 1'b1;
        settle(); check_stall("mem_load_nobranch", 1'b0);
        // Reserved md op does not start the unit
        clear_inputs(); id_ex_md_op = 2'b11; if_id_hilo_use = 1'b1;
        settle();
        check("rsvd.md_start", {31'd0, md_start}, 32'd0);
        check_stall("rsvd", 1'b0);
        tick(); clear_inputs(); settle();
        check("rsvd.md_busy", {31'd0, md_busy}, 32'd0);

        // Div with mflo arriving the cycle after start: 32 stall cycles
        id_ex_md_op = 2'b10;
        settle();
        check("div1.md_start", {31'd0, md_start}, 32'd1);
        check_stall("div1.start", 1'b0);
        tick(); id_ex_md_op = 2'b00; if_id_hilo_use = 1'b1;
        n_busy = 0;
        for (int i = 0; i < 40 && md_busy; i++) begin
            if (i == 5) id_ex_md_op = 2'b01;
            settle();
            if (i == 5) check("div1.no_restart", {31'd0, md_start}, 32'd0);
            if (!pc_stall) check("div1.stall_in_busy", {31'd0, pc_stall}, 32'd1);
            n_busy++;
            tick(); id_ex_md_op = 2'b00;
        end
        check("div1.busy_cycles", n_busy, 32);
        settle();
        check_stall("div1.done", 1'b0);
        check_counters("after_div", 35);
        tick(); clear_inputs();

        // Div with mflo right behind: start + 32 busy = 33 held cycles
        id_ex_md_op = 2'b10; if_id_hilo_use = 1'b1;
        n_stall = 0; n_busy = 0;
        for (int i = 0; i < 50; i++) begin
            settle();
            if (i == 0) check("div2.md_start", {31'd0, md_start}, 32'd1);
            if (pc_stall) n_stall++;
            if (md_busy) n_busy++;
            tick(); id_ex_md_op = 2'b00;
        end
        check("div2.stall_cycles", n_stall, 33);
        check("div2.busy_cycles", n_busy, 32);

        // Branch: EX ALU producer stalls, MEM non-load producer does not
        clear_inputs();
        if_id_branch = 1'b1; if_id_rs = 5'd8; if_id_use_rs = 1'b1;
        id_ex_regwrite = 1'b1; id_ex_regdst = 5'd8;
        settle(); check_stall("br_ex", 1'b1);
        tick(); id_ex_regwrite = 1'b0; id_ex_regdst = 5'd0; ex_mem_regdst = 5'd8;
        settle(); check_stall("br_mem_alu", 1'b0);
        // Branch after load: 2 stall cycles
        tick(); ex_mem_regdst = 5'd0;
        id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_regdst = 5'd8;
        settle(); check_stall("brld_ex", 1'b1);
        tick(); id_ex_memread = 1'b0; id_ex_regwrite = 1'b0; id_ex_regdst = 5'd0;
        ex_mem_memread = 1'b1; ex_mem_regdst = 5'd8;
        settle(); check_stall("brld_mem", 1'b1);
        tick(); ex_mem_memread = 1'b0; ex_mem_regdst = 5'd0;
        settle(); check_stall("brld_done", 1'b0);

        // Reset at BUSY cycle 10 of a div, then a mul runs 4 BUSY cycles
        tick(); clear_inputs();
        id_ex_md_op = 2'b10;
        tick(); id_ex_md_op = 2'b00; if_id_hilo_use = 1'b1;
        repeat (9) tick();
        settle(); check("midrst.busy_before", {31'd0, md_busy}, 32'd1);
        rst = 1'b1;
        settle();
        check("midrst.busy_in_rst", {31'd0, md_busy}, 32'd0);
        check_stall("midrst.in_rst", 1'b0);
        check_counters("midrst.in_rst", 0);
        tick(); rst = 1'b0;
        settle();
        check("midrst.busy_after", {31'd0, md_busy}, 32'd0);
        check_stall("midrst.after", 1'b0);
        id_ex_md_op = 2'b01;
        settle();
        check("mul.md_start", {31'd0, md_start}, 32'd1);
        check_stall("mul.start_hilo", 1'b1);
        tick(); id_ex_md_op = 2'b00;
        n_busy = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (md_busy) n_busy++;
            tick();
        end
        check("mul.busy_cycles", n_busy, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
